// File: rtl/ser_arbiter_if.sv
// ser_arbiter_if: request-side and serializer-side signals of ser_arbiter.
// The arbiter connects through the slave modport; the environment that
// supplies channel words and the serializer busy flag uses the master modport.
interface ser_arbiter_if #(
    parameter int NUM_CH         = 4,
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4
);
    localparam int GRANT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*DATA_BUS_WIDTH-1:0] req_data_i;
    logic [NUM_CH*DATA_MOD_WIDTH-1:0] req_mod_i;
    logic [NUM_CH-1:0]                req_val_i;
    logic [NUM_CH-1:0]                req_ready_o;
    logic [DATA_BUS_WIDTH-1:0]        ser_data_o;
    logic [DATA_MOD_WIDTH-1:0]        ser_mod_o;
    logic                             ser_val_o;
    logic                             ser_busy_i;
    logic [GRANT_W-1:0]               grant_id_o;
    logic                             busy_o;
    logic                             drop_o;
    logic                             timeout_o;

    modport slave (
        input  req_data_i, req_mod_i, req_val_i, ser_busy_i,
        output req_ready_o, ser_data_o, ser_mod_o, ser_val_o,
               grant_id_o, busy_o, drop_o, timeout_o
    );

    modport master (
        output req_data_i, req_mod_i, req_val_i, ser_busy_i,
        input  req_ready_o, ser_data_o, ser_mod_o, ser_val_o,
               grant_id_o, busy_o, drop_o, timeout_o
    );
endinterface

// File: rtl/ser_arbiter.sv
// ser_arbiter: shares one serializer between NUM_CH word sources.
// A winner is picked in IDLE_S (round-robin from the last winner), its word
// and mod are latched and strobed into the serializer, then the arbiter waits
// for the serializer to go busy and finish before arbitrating again.
// Words with mod 1 or 2 are accepted but dropped (drop_o pulse).
// If the serializer never raises busy within BUSY_TIMEOUT cycles in
// WAIT_BUSY_S, timeout_o pulses and the arbiter returns to IDLE_S.
// Optional feature: define SER_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (lowest-index valid channel wins, no rotation pointer).
module ser_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4,
    parameter int BUSY_TIMEOUT   = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    ser_arbiter_if.slave  bus
);
    localparam int GRANT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE_S      = 2'd0,
        ISSUE_S     = 2'd1,
        WAIT_BUSY_S = 2'd2,
        WAIT_DONE_S = 2'd3
    } state_t;

    // Mods 1 and 2 have no meaning for the serializer and must never reach it.
    function automatic logic is_illegal_mod(input logic [DATA_MOD_WIDTH-1:0] mod);
        return (mod == DATA_MOD_WIDTH'(1)) || (mod == DATA_MOD_WIDTH'(2));
    endfunction

    state_t                    state_r;
    state_t                    state_nxt_s;
`ifndef SER_ARB_FIXED_PRIO_EN
    logic [GRANT_W-1:0]        ptr_r;
`endif
    logic [GRANT_W-1:0]        cand_s;
    logic [GRANT_W-1:0]        win_idx_s;
    logic                      win_found_s;
    logic [DATA_BUS_WIDTH-1:0] win_data_s;
    logic [DATA_MOD_WIDTH-1:0] win_mod_s;
    logic [NUM_CH-1:0]         ready_s;
    logic                      accept_s;
    logic                      load_s;
    logic                      drop_nxt_s;
    logic                      issue_nxt_s;
    logic                      timeout_nxt_s;
    logic [CNT_W-1:0]          cnt_nxt_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [DATA_BUS_WIDTH-1:0] data_r;
    logic [DATA_MOD_WIDTH-1:0] mod_r;
    logic [GRANT_W-1:0]        grant_r;
    logic                      ser_val_r;
    logic                      drop_r;
    logic                      timeout_r;
    logic                      busy_r;

    // Winner search: first valid channel after the last winner (or from ch0 in fixed priority).
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef SER_ARB_FIXED_PRIO_EN
            cand_s = GRANT_W'(i);
`else
            cand_s = GRANT_W'((int'(ptr_r) + 1 + i) % NUM_CH);
`endif
            if (!win_found_s && bus.req_val_i[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign win_data_s = bus.req_data_i[win_idx_s*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
    assign win_mod_s  = bus.req_mod_i[win_idx_s*DATA_MOD_WIDTH +: DATA_MOD_WIDTH];

    // Next-state and per-cycle control; ready is gated by reset so outputs read 0 while held in reset.
    always_comb begin
        state_nxt_s   = state_r;
        ready_s       = '0;
        accept_s      = 1'b0;
        load_s        = 1'b0;
        drop_nxt_s    = 1'b0;
        issue_nxt_s   = 1'b0;
        timeout_nxt_s = 1'b0;
        cnt_nxt_s     = cnt_r;
        case (state_r)
            IDLE_S: begin
                if (win_found_s && rst_n_i) begin
                    ready_s[win_idx_s] = 1'b1;
                    accept_s           = 1'b1;
                    if (is_illegal_mod(win_mod_s)) begin
                        drop_nxt_s  = 1'b1;
                        state_nxt_s = IDLE_S;
                    end else begin
                        load_s      = 1'b1;
                        issue_nxt_s = 1'b1;
                        state_nxt_s = ISSUE_S;
                    end
                end else begin
                    state_nxt_s = IDLE_S;
                end
            end
            ISSUE_S: begin
                cnt_nxt_s   = '0;
                state_nxt_s = WAIT_BUSY_S;
            end
            WAIT_BUSY_S: begin
                if (bus.ser_busy_i) begin
                    state_nxt_s = WAIT_DONE_S;
                end else if (cnt_r == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = IDLE_S;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            WAIT_DONE_S: begin
                if (!bus.ser_busy_i) begin
                    state_nxt_s = IDLE_S;
                end else begin
                    state_nxt_s = WAIT_DONE_S;
                end
            end
            default: begin
                state_nxt_s = IDLE_S;
            end
        endcase
    end

    // State, rotation pointer, latched word and registered output strobes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r   <= IDLE_S;
`ifndef SER_ARB_FIXED_PRIO_EN
            ptr_r     <= GRANT_W'(NUM_CH - 1);
`endif
            cnt_r     <= '0;
            data_r    <= '0;
            mod_r     <= '0;
            grant_r   <= '0;
            ser_val_r <= 1'b0;
            drop_r    <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            ser_val_r <= issue_nxt_s;
            drop_r    <= drop_nxt_s;
            timeout_r <= timeout_nxt_s;
            busy_r    <= (state_nxt_s != IDLE_S);
`ifndef SER_ARB_FIXED_PRIO_EN
            if (accept_s) begin
                ptr_r <= win_idx_s;
            end else begin
                ptr_r <= ptr_r;
            end
`endif
            if (load_s) begin
                data_r  <= win_data_s;
                mod_r   <= win_mod_s;
                grant_r <= win_idx_s;
            end else begin
                data_r  <= data_r;
                mod_r   <= mod_r;
                grant_r <= grant_r;
            end
        end
    end

    assign bus.req_ready_o = ready_s;
    assign bus.ser_data_o  = data_r;
    assign bus.ser_mod_o   = mod_r;
    assign bus.ser_val_o   = ser_val_r;
    assign bus.grant_id_o  = grant_r;
    assign bus.busy_o      = busy_r;
    assign bus.drop_o      = drop_r;
    assign bus.timeout_o   = timeout_r;
endmodule

// File: tb/tb_ser_arbiter.sv
// tb_ser_arbiter: directed scenarios plus a randomized run, all compared every
// cycle against a transaction-level reference of the arbiter, with a stub
// serializer that raises busy after a programmable delay.
module tb_ser_arbiter;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int M  = 4;
    localparam int TO = 4;

    logic clk;
    logic rst_n;

    ser_arbiter_if #(.NUM_CH(N), .DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M)) bus ();

    ser_arbiter #(
        .NUM_CH(N), .DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M), .BUSY_TIMEOUT(TO)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- stub serializer ----------------
    bit stub_rand  = 1'b0;
    int stub_delay = 1;   // 0 = never goes busy
    int stub_len   = 16;

    initial begin
        int d;
        int l;
        bus.ser_busy_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.ser_val_o) begin
                d = stub_delay;
                l = stub_len;
                if (stub_rand) begin
                    d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
                    l = $urandom_range(1, 6);
                end
                if (d != 0) begin
                    repeat (d) @(posedge clk);
                    #1 bus.ser_busy_i = 1'b1;
                    repeat (l) @(posedge clk);
                    #1 bus.ser_busy_i = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic [N-1:0] acc_seen;
    int           m_ptr;
    bit           m_active;
    int           m_age;
    bit           m_seen_busy;
    logic [W-1:0] e_data;
    logic [M-1:0] e_mod;
    int           e_grant;
    bit           e_val, e_drop, e_to;

    initial begin
        int           win;
        int           c;
        logic [M-1:0] md;
        logic [N-1:0] e_ready;
        acc_seen = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ptr = N - 1; m_active = 0; m_age = 0; m_seen_busy = 0;
                e_data = '0; e_mod = '0; e_grant = 0; e_val = 0; e_drop = 0; e_to = 0;
                acc_seen = '0;
                chk("rst_ready",   bus.req_ready_o, 0);
                chk("rst_ser_val", bus.ser_val_o, 0);
                chk("rst_busy",    bus.busy_o, 0);
                chk("rst_data",    bus.ser_data_o, 0);
                chk("rst_grant",   bus.grant_id_o, 0);
            end else begin
                chk("m_ser_val", bus.ser_val_o, e_val);
                chk("m_drop",    bus.drop_o, e_drop);
                chk("m_timeout", bus.timeout_o, e_to);
                chk("m_busy",    bus.busy_o, m_active);
                chk("m_data",    bus.ser_data_o, e_data);
                chk("m_mod",     bus.ser_mod_o, e_mod);
                chk("m_grant",   bus.grant_id_o, e_grant);
                win = -1;
                for (int i = 0; i < N; i++) begin
`ifdef SER_ARB_FIXED_PRIO_EN
                    c = i;
`else
                    c = (m_ptr + 1 + i) % N;
`endif
                    if (win < 0 && bus.req_val_i[c]) win = c;
                end
                e_ready = '0;
                if (!m_active && win >= 0) e_ready[win] = 1'b1;
                chk("m_ready", bus.req_ready_o, e_ready);
                acc_seen = bus.req_ready_o & bus.req_val_i;
                e_val = 0; e_drop = 0; e_to = 0;
                if (!m_active) begin
                    if (win >= 0) begin
                        m_ptr = win;
                        md = bus.req_mod_i[win*M +: M];
                        if (md == 1 || md == 2) begin
                            e_drop = 1;
                        end else begin
                            m_active = 1; m_age = 0; m_seen_busy = 0;
                            e_data = bus.req_data_i[win*W +: W];
                            e_mod = md; e_grant = win; e_val = 1;
                        end
                    end
                end else begin
                    m_age++;
                    if (m_age >= 2) begin
                        if (m_seen_busy) begin
                            if (!bus.ser_busy_i) m_active = 0;
                        end else if (bus.ser_busy_i) begin
                            m_seen_busy = 1;
                        end else if (m_age == TO + 1) begin
                            m_active = 0; e_to = 1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int k, input logic [W-1:0] d, input logic [M-1:0] md);
        bus.req_data_i[k*W +: W] = d;
        bus.req_mod_i[k*M +: M]  = md;
        bus.req_val_i[k]         = 1'b1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            bus.req_val_i = bus.req_val_i & ~acc_seen;
            if (bus.req_val_i == '0 && !bus.busy_o && !bus.ser_busy_i) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_drain"}, ok, 1);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int  order [5];
        int  exp_order [5];
        int  got;
        bit  seen_hi;
        bit  done;
        rst_n = 1'b0;
        bus.req_data_i = '0;
        bus.req_mod_i  = '0;
        bus.req_val_i  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single word, busy for 16 cycles
        stub_delay = 1; stub_len = 16;
        set_req(0, 16'hA5A5, 4'd0);
        @(negedge clk); chk("t1_ready", bus.req_ready_o, 4'b0001);
        @(posedge clk); #1 bus.req_val_i[0] = 1'b0;
        @(negedge clk);
        chk("t1_ser_val", bus.ser_val_o, 1'b1);
        chk("t1_ser_data", bus.ser_data_o, 16'hA5A5);
        seen_hi = 1'b0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.ser_busy_i) seen_hi = 1'b1;
            else if (seen_hi) begin
                chk("t1_busy_hold", bus.busy_o, 1'b1);
                @(negedge clk);
                chk("t1_busy_drop", bus.busy_o, 1'b0);
                done = 1'b1;
            end
        end
        chk("t1_busy_bound", done, 1'b1);

        // 2: all channels valid continuously
        pulse_reset();
        stub_delay = 1; stub_len = 2;
        for (int k = 0; k < N; k++) set_req(k, W'(16'h1000 + k), 4'd0);
        got = 0;
        for (int c = 0; c < 300 && got < 5; c++) begin
            @(negedge clk);
            if (bus.req_ready_o != '0) begin
                order[got] = onehot_idx(bus.req_ready_o);
                got++;
                @(posedge clk); #1;
            end
        end
        chk("t2_count", got, 5);
`ifdef SER_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), order[i], exp_order[i]);
        @(posedge clk); #1 bus.req_val_i = '0;
        drain("t2");

        // 3: illegal mod on ch2 is dropped, pointer still moves to ch2
        set_req(2, 16'hBEEF, 4'd1);
        @(negedge clk); chk("t3_ready", bus.req_ready_o, 4'b0100);
        @(posedge clk); #1 bus.req_val_i[2] = 1'b0;
        @(negedge clk);
        chk("t3_drop", bus.drop_o, 1'b1);
        chk("t3_no_val", bus.ser_val_o, 1'b0);
        @(posedge clk); #1;
        set_req(1, 16'h0111, 4'd0);
        set_req(2, 16'h0222, 4'd3);
        set_req(3, 16'h0333, 4'd0);
        @(negedge clk);
`ifdef SER_ARB_FIXED_PRIO_EN
        chk("t3_ptr", bus.req_ready_o, 4'b0010);
`else
        chk("t3_ptr", bus.req_ready_o, 4'b1000);
`endif
        drain("t3");

        // 4: serializer never goes busy
        stub_delay = 0;
        set_req(0, 16'h5A5A, 4'd3);
        @(negedge clk); chk("t4_ready", bus.req_ready_o, 4'b0001);
        @(posedge clk); #1 bus.req_val_i[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) chk("t4_ser_val", bus.ser_val_o, 1'b1);
            if (k == 5) begin
                chk("t4_to_early", bus.timeout_o, 1'b0);
                chk("t4_busy_wait", bus.busy_o, 1'b1);
            end
            if (k == 6) begin
                chk("t4_timeout", bus.timeout_o, 1'b1);
                chk("t4_idle", bus.busy_o, 1'b0);
            end
            if (k == 7) chk("t4_to_single", bus.timeout_o, 1'b0);
        end
        drain("t4");

        // 5: reset during WAIT_DONE_S
        stub_delay = 1; stub_len = 30;
        set_req(2, 16'hC3C3, 4'd5);
        @(negedge clk); chk("t5_ready", bus.req_ready_o, 4'b0100);
        @(posedge clk); #1 bus.req_val_i[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) set_req(k, W'(16'h2000 + k), 4'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", bus.busy_o, 1'b0);
        chk("t5_data", bus.ser_data_o, 16'h0000);
        chk("t5_mod", bus.ser_mod_o, 4'd0);
        chk("t5_ready_rst", bus.req_ready_o, 4'b0000);
        repeat (32) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); chk("t5_first", bus.req_ready_o, 4'b0001);
        drain("t5");

`ifdef SER_ARB_FIXED_PRIO_EN
        // 6: fixed priority starves ch3 behind ch1
        stub_delay = 1; stub_len = 2;
        set_req(1, 16'h1111, 4'd0);
        set_req(3, 16'h3333, 4'd0);
        got = 0;
        for (int c = 0; c < 200 && got < 4; c++) begin
            @(negedge clk);
            if (bus.req_ready_o != '0) begin
                chk("t6_grant", bus.req_ready_o, 4'b0010);
                got++;
                @(posedge clk); #1;
            end
        end
        chk("t6_count", got, 4);
        @(posedge clk); #1 bus.req_val_i = '0;
        drain("t6");
`endif

        // randomized traffic
        stub_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.req_val_i = bus.req_val_i & ~acc_seen;
            for (int k = 0; k < N; k++) begin
                if (!bus.req_val_i[k] && $urandom_range(0, 3) == 0) begin
                    set_req(k, W'($urandom),
                            ($urandom_range(0, 5) == 0) ? M'($urandom_range(1, 2))
                                                        : M'($urandom_range(0, 15)));
                end
            end
        end
        drain("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
